serial_sub: RTL and testbench

- Bit-serial, LSB-first subtractor for the ALU project. It is the inverse operation of the existing single-bit full adder.
- Computes out = a - b - Bin over WIDTH clock cycles. Each cycle uses one single-bit full-subtractor cell.
- A start/busy/done handshake lets an ALU controller trade area for latency when it issues a subtraction.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_full_sub.sv | 13 +
 rtl/serial_sub.sv | 98 +++++++++
 tb/tb_serial_sub.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor cell, the mirror of the ALU's full adder cell.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic out,
  output logic Bout
);

  assign out  = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: out = a - b - Bin over WIDTH cycles using one full_sub cell.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             Bout,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is accepted only in IDLE; busy is high for the WIDTH cycles
  // of RUN; done pulses for one cycle when out/Bout become valid; out/Bout then
  // hold until the next completion.
  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             brw_next;

  full_sub u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .Bin  (brw),
    .out  (d),
    .Bout (brw_next)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      Bout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= Bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= brw_next;
          res  <= {d, res[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          // The last bit publishes the full result; out never shows partial values.
          if (cnt == CW'(WIDTH - 1)) begin
            out   <= {d, res[WIDTH-1:1]};
            Bout  <= brw_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases, handshake corner cases and random ops.
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         Bout;
  state_t       dbg_state;

  logic fa, fb, fbin, fd, fbo;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] last_out;
  logic         last_bout;

  // clock / reset
  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .Bin       (Bin),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .Bout      (Bout),
    .dbg_state (dbg_state)
  );

  full_sub u_fs (
    .a    (fa),
    .b    (fb),
    .Bin  (fbin),
    .out  (fd),
    .Bout (fbo)
  );

  // reference: plain integer subtraction, {borrow, difference mod 2^W}
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic bi);
    int diff;
    logic [W-1:0] r;
    diff = int'(x) - int'(y) - int'(bi);
    r = W'(diff + (1 << W));
    return {(diff < 0), r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; Bin = 1'b0;
    #3;
    tests_run++;
    if ({busy, done, out, Bout, 2'(dbg_state)} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 2'(S_IDLE)}) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h Bout=%b st=%0d, need all 0",
               busy, done, out, Bout, dbg_state);
    end
    // start held during reset must be ignored
    start = 1'b1; a = 8'h12; b = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_vs_start: got busy=%b st=%0d, need busy=0 st=0", busy, dbg_state);
    end
    last_out = '0; last_bout = 1'b0;
  endtask

  task automatic test_full_sub();
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      fa = i[2]; fb = i[1]; fbin = i[0];
      e = 2'(int'(fa) - int'(fb) - int'(fbin));
      #1;
      tests_run++;
      if ({fbo, fd} !== {e[1], e[0]}) begin
        tests_failed++;
        $display("FAIL full_sub_%0d: got Bout=%b d=%b, need Bout=%b d=%b", i, fbo, fd, e[1], e[0]);
      end
    end
  endtask

  // driver + scoreboard for one op; inj >= 0 pulses a competing start in RUN and DONE
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input int inj, input string tag);
    logic [W:0] e;
    int k, nbusy;
    bit hold_ok;
    @(negedge clk);
    a = ia; b = ib; Bin = ibin; start = 1'b1;
    exp_q.push_back(model(ia, ib, ibin));
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); Bin = 1'($urandom);
    k = 0; nbusy = 0; hold_ok = 1'b1;
    while (done !== 1'b1 && k < W + 4) begin
      if (busy === 1'b1) nbusy++;
      if (out !== last_out || Bout !== last_bout) hold_ok = 1'b0;
      if (k == inj) begin
        start = 1'b1; a = 8'h10; b = 8'h10; Bin = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      start = 1'b0;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, W + 4);
    end
    tests_run++;
    if ({Bout, out} !== e) begin
      tests_failed++;
      $display("FAIL %s_result: a=%h b=%h Bin=%b got out=%h Bout=%b, need out=%h Bout=%b",
               tag, ia, ib, ibin, out, Bout, e[W-1:0], e[W]);
    end
    tests_run++;
    if (k != W || nbusy != W) begin
      tests_failed++;
      $display("FAIL %s_latency: got done after %0d edges, busy %0d cycles, need %0d/%0d",
               tag, k, nbusy, W, W);
    end
    tests_run++;
    if (!hold_ok) begin
      tests_failed++;
      $display("FAIL %s_hold: out/Bout changed before done, need %h/%b held", tag, last_out, last_bout);
    end
    last_out = e[W-1:0]; last_bout = e[W];
    if (inj >= 0) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL %s_post: got done=%b busy=%b st=%0d, need 0/0/IDLE", tag, done, busy, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, -1, "d_05_03");
    run_op(8'h03, 8'h05, 1'b0, -1, "d_03_05");
    run_op(8'h00, 8'h00, 1'b1, -1, "d_00_00_b");
    run_op(8'hFF, 8'hFF, 1'b0, -1, "d_ff_ff");
  endtask

  task automatic test_ignore_start();
    bit extra;
    run_op(8'h80, 8'h01, 1'b0, 3, "ignore");
    extra = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    tests_run++;
    if (extra) begin
      tests_failed++;
      $display("FAIL ignore_single_done: got extra busy/done, need none");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    a = 8'h40; b = 8'h20; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, out, Bout, 2'(dbg_state)} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 2'(S_IDLE)}) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b done=%b out=%h Bout=%b st=%0d, need all 0",
               busy, done, out, Bout, dbg_state);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got done pulse after abort, need none");
    end
    last_out = '0; last_bout = 1'b0;
    run_op(8'h40, 8'h20, 1'b0, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(8'h12, 8'h34, 1'b1, -1, "b2b_first");
    run_op(8'hAA, 8'h55, 1'b0, -1, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1, "rand");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    fa = 1'b0; fb = 1'b0; fbin = 1'b0;
    test_reset();
    test_full_sub();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
